// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner encodings for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
// req[0] is the CPU, req[1] the loader; on a conflict the side that did not win last time is granted.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == OWN_CPU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one unified memory between the CPU core and the program loader
// Each access runs IDLE -> ISSUE -> WAIT -> DONE with the requester fields latched at grant time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_hold,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        req;
    logic [1:0]        gnt;

    assign req = {ldr_req, cpu_req & ~boot_hold};

    rr_arbiter2 u_rr (
        .req  (req),
        .last (owner),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner     <= OWN_LDR;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        owner     <= gnt[1] ? OWN_LDR : OWN_CPU;
                        lat_we    <= gnt[1] ? ldr_we : cpu_we;
                        lat_addr  <= gnt[1] ? ldr_addr : cpu_addr;
                        lat_wdata <= gnt[1] ? ldr_wdata : cpu_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= WAIT;
                end
                WAIT: begin
                    // cnt hits zero in the cycle mem_rdata becomes valid
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (owner == OWN_LDR) begin
                                ldr_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = (state != IDLE);
    assign cpu_done  = (state == DONE) && (owner == OWN_CPU);
    assign ldr_done  = (state == DONE) && (owner == OWN_LDR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized check of mem_port_arbiter (MEM_LAT 1 and 3) against a transaction model
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, boot_hold;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, mem_rdata;

    logic [1:0]  cpu_done, ldr_done, mem_en, mem_we, busy, owner;
    logic [31:0] cpu_rdata [2];
    logic [31:0] ldr_rdata [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2 * g + 1)) dut (
            .clk       (clk),
            .rst       (rst),
            .boot_hold (boot_hold),
            .cpu_req   (cpu_req),
            .cpu_we    (cpu_we),
            .cpu_addr  (cpu_addr),
            .cpu_wdata (cpu_wdata),
            .cpu_done  (cpu_done[g]),
            .cpu_rdata (cpu_rdata[g]),
            .ldr_req   (ldr_req),
            .ldr_we    (ldr_we),
            .ldr_addr  (ldr_addr),
            .ldr_wdata (ldr_wdata),
            .ldr_done  (ldr_done[g]),
            .ldr_rdata (ldr_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata),
            .busy      (busy[g]),
            .owner     (owner[g])
        );
    end

    // Model: age = cycles since the grant (0 = idle, 1 = strobe, lat+2 = done cycle)
    int          m_age   [2];
    logic        m_gnt   [2];
    logic        m_own   [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_crd   [2];
    logic [31:0] m_lrd   [2];

    int cyc;
    int n_cmp;
    int n_bad;

    function automatic int lat_of(input int k);
        return 2 * k + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            int   lat    = lat_of(k);
            logic cpu_ok = cpu_req & ~boot_hold;
            if (rst) begin
                m_age[k]   = 0;
                m_own[k]   = 1'b1;
                m_we[k]    = 1'b0;
                m_addr[k]  = '0;
                m_wdata[k] = '0;
                m_crd[k]   = '0;
                m_lrd[k]   = '0;
            end else if (m_age[k] != 0) begin
                if (m_age[k] == lat + 1 && !m_we[k]) begin
                    if (m_gnt[k]) m_lrd[k] = mem_rdata;
                    else          m_crd[k] = mem_rdata;
                end
                m_age[k] = (m_age[k] == lat + 2) ? 0 : m_age[k] + 1;
            end else if (cpu_ok || ldr_req) begin
                m_gnt[k]   = (cpu_ok && ldr_req) ? ~m_own[k] : ldr_req;
                m_own[k]   = m_gnt[k];
                m_we[k]    = m_gnt[k] ? ldr_we : cpu_we;
                m_addr[k]  = m_gnt[k] ? ldr_addr : cpu_addr;
                m_wdata[k] = m_gnt[k] ? ldr_wdata : cpu_wdata;
                m_age[k]   = 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int   lat = lat_of(k);
            logic fin = (m_age[k] == lat + 2);
            check($sformatf("L%0d busy", lat),      32'(busy[k]),     32'(m_age[k] != 0));
            check($sformatf("L%0d mem_en", lat),    32'(mem_en[k]),   32'(m_age[k] == 1));
            check($sformatf("L%0d mem_we", lat),    32'(mem_we[k]),   32'(m_age[k] == 1 && m_we[k]));
            check($sformatf("L%0d mem_addr", lat),  mem_addr[k],      m_addr[k]);
            check($sformatf("L%0d mem_wdata", lat), mem_wdata[k],     m_wdata[k]);
            check($sformatf("L%0d cpu_done", lat),  32'(cpu_done[k]), 32'(fin && !m_gnt[k]));
            check($sformatf("L%0d ldr_done", lat),  32'(ldr_done[k]), 32'(fin && m_gnt[k]));
            check($sformatf("L%0d cpu_rdata", lat), cpu_rdata[k],     m_crd[k]);
            check($sformatf("L%0d ldr_rdata", lat), ldr_rdata[k],     m_lrd[k]);
            check($sformatf("L%0d owner", lat),     32'(owner[k]),    32'(m_own[k]));
        end
    endtask

    // Inputs set by the caller are sampled at the next rising edge; outputs are checked at the falling edge after it.
    task automatic step();
        model_advance();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    int t0;
    int done_at  [2];
    int en_cnt   [2];
    int last_en  [2];
    logic exp_own [2];
    int hold_done;
    logic seen   [2];

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        rst = 1'b1; boot_hold = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 2; k++) check("reset owner", 32'(owner[k]), 32'd1);

        // CPU read, request dropped after one cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; mem_rdata = 32'h2008_0005;
        t0 = cyc;
        for (int k = 0; k < 2; k++) done_at[k] = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            cpu_req = 1'b0;
            cpu_addr = $urandom;
            for (int k = 0; k < 2; k++) if (cpu_done[k] && done_at[k] < 0) done_at[k] = cyc;
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d read latency", lat_of(k)), 32'(done_at[k] - t0), 32'(lat_of(k) + 2));
            check($sformatf("L%0d read data", lat_of(k)), cpu_rdata[k], 32'h2008_0005);
        end

        // Loader write
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h10; ldr_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) en_cnt[k] = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ldr_req = 1'b0; ldr_addr = $urandom; ldr_wdata = $urandom; mem_rdata = $urandom;
            for (int k = 0; k < 2; k++) if (mem_en[k]) begin
                en_cnt[k]++;
                check("write we", 32'(mem_we[k]), 32'd1);
                check("write addr", mem_addr[k], 32'h10);
                check("write data", mem_wdata[k], 32'hDEAD_BEEF);
            end
        end
        for (int k = 0; k < 2; k++) begin
            check("write strobes", 32'(en_cnt[k]), 32'd1);
            check("write owner", 32'(owner[k]), 32'd1);
            check("write ldr_rdata", ldr_rdata[k], 32'd0);
        end

        // Both requesting continuously: strict alternation starting with the CPU
        cpu_req = 1'b1; ldr_req = 1'b1; cpu_we = 1'b0; ldr_we = 1'b0;
        for (int k = 0; k < 2; k++) begin last_en[k] = -1; exp_own[k] = 1'b0; end
        for (int i = 0; i < 30; i++) begin
            cpu_addr = $urandom; ldr_addr = $urandom; mem_rdata = $urandom;
            step();
            for (int k = 0; k < 2; k++) if (mem_en[k]) begin
                if (last_en[k] >= 0) check($sformatf("L%0d strobe gap", lat_of(k)), 32'(cyc - last_en[k]), 32'(lat_of(k) + 3));
                check($sformatf("L%0d alternation", lat_of(k)), 32'(owner[k]), 32'(exp_own[k]));
                exp_own[k] = ~exp_own[k];
                last_en[k] = cyc;
            end
        end

        // boot_hold: loader only, then CPU wins at the first IDLE after release
        boot_hold = 1'b1;
        hold_done = 0;
        for (int i = 0; i < 24; i++) begin
            mem_rdata = $urandom;
            step();
            if (i >= 8) hold_done += int'(cpu_done[0]) + int'(cpu_done[1]);
        end
        check("cpu_done under boot_hold", 32'(hold_done), 32'd0);
        boot_hold = 1'b0;
        for (int k = 0; k < 2; k++) seen[k] = 1'b0;
        for (int i = 0; i < 20 && !(seen[0] && seen[1]); i++) begin
            step();
            for (int k = 0; k < 2; k++) if (mem_en[k] && !seen[k]) begin
                seen[k] = 1'b1;
                check($sformatf("L%0d grant after release", lat_of(k)), 32'(owner[k]), 32'd0);
            end
        end
        for (int k = 0; k < 2; k++) check("release strobe seen", 32'(seen[k]), 32'd1);

        // Reset during WAIT abandons the access
        idle(10);
        cpu_req = 1'b1; cpu_we = 1'b0;
        step();
        cpu_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("busy after reset", 32'(busy[k]), 32'd0);
            check("owner after reset", 32'(owner[k]), 32'd1);
        end
        cpu_req = 1'b1; mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 2; k++) seen[k] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            cpu_req = 1'b0;
            for (int k = 0; k < 2; k++) if (cpu_done[k]) seen[k] = 1'b1;
        end
        for (int k = 0; k < 2; k++) check("fresh access after reset", 32'(seen[k]), 32'd1);

        // Random traffic, including mid-access drops, field changes, boot_hold toggles and resets
        for (int i = 0; i < 2000; i++) begin
            cpu_req   = ($urandom_range(0, 99) < 60);
            ldr_req   = ($urandom_range(0, 99) < 50);
            cpu_we    = 1'($urandom_range(0, 1));
            ldr_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            ldr_addr  = $urandom;
            ldr_wdata = $urandom;
            mem_rdata = $urandom;
            if ($urandom_range(0, 49) == 0) boot_hold = ~boot_hold;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
